imem_stream_loader: RTL

- Avalon-MM write master that boot-loads a SoC instruction memory from a byte stream, such as a UART or JTAG bridge.
- Packs 4 bytes into each little-endian 32-bit word and writes words to consecutive word addresses starting at 0.
- Holds the attached processor in reset until the full image is written, then releases it.
- Drives the s1 port of a single-port on-chip memory with zero wait states and 1-cycle read latency.

---
 rtl/imem_stream_loader.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// -----------------------------------------------------------------------------
// imem_stream_loader
//
// Boot loader that fills a processor instruction memory from a byte stream,
// such as a UART or JTAG bridge. It acts as an Avalon-MM write master on the
// s1 port of a single-port on-chip RAM. That RAM has zero wait states and
// 1-cycle read latency.
//
// Every 4 accepted bytes form one little-endian 32-bit word. The first byte
// received is the least significant. Words go to consecutive word addresses,
// starting at 0. The attached core is held in reset until all WORD_COUNT
// words have been written. The loader then releases it.
//
// Optional build macro: IMEM_LOADER_READBACK_VERIFY_EN
//   Each write is followed by a read of the same address and a compare.
//   A mismatch stops the load in an error state. The core stays in reset
//   until the next start.
//
// Parameters
//   ADDR_W      memory word-address width
//   WORD_COUNT  number of 32-bit words per load (1 .. 2**ADDR_W)
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   start           single-cycle pulse, begins (or restarts) a load
//   in_data         stream byte
//   in_valid        in_data valid
//   in_ready        byte accepted this cycle when in_valid is high (decoded)
//   avm_address     memory word address
//   avm_byteenable  byte lanes, 4'hF during an access, 0 when idle
//   avm_chipselect  memory select
//   avm_write       write strobe
//   avm_writedata   write data
//   avm_readdata    memory read data (used only by the readback build)
//   busy            load in progress
//   done            image fully loaded
//   error           readback mismatch (constant 0 without the readback build)
//   core_reset_n    processor reset, low holds the core in reset
//   word_count      words written in the current or last load
// -----------------------------------------------------------------------------
module imem_stream_loader #(
    parameter int ADDR_W     = 8,
    parameter int WORD_COUNT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_reset_n,
    output logic [ADDR_W:0]   word_count
);

    // The last address is WORD_COUNT-1. With WORD_COUNT = 2**ADDR_W this is
    // all-ones, so the address counter never has to wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3
`ifdef IMEM_LOADER_READBACK_VERIFY_EN
        ,
        VRD     = 3'd4,
        VCHK    = 3'd5,
        ERROR   = 3'd6
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic [31:0]       word_q;
    logic [31:0]       word_nxt;
    logic              accept;
    logic              restart;
    logic              step;
    logic              last_word;
    logic              bus_sel_nxt;
    logic              busy_nxt;

    assign in_ready  = (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign last_word = (addr == LAST_ADDR);

    // Next state. restart clears the load counters. step advances to the
    // next word address once a word has been fully handled.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                    restart   = 1'b1;
                end
            end
            COLLECT: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
`ifdef IMEM_LOADER_READBACK_VERIFY_EN
                state_nxt = VRD;
`else
                if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                    step      = 1'b1;
                end
`endif
            end
`ifdef IMEM_LOADER_READBACK_VERIFY_EN
            VRD: begin
                state_nxt = VCHK;
            end
            VCHK: begin
                // Read data for the VRD address arrives here (1-cycle latency).
                if (avm_readdata != word_q) begin
                    state_nxt = ERROR;
                end else if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                    step      = 1'b1;
                end
            end
            ERROR: begin
                if (start) begin
                    state_nxt = COLLECT;
                    restart   = 1'b1;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    state_nxt = COLLECT;
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The registered outputs are loaded from the next state. This makes the
    // bus strobes and status flags line up exactly with the state they
    // describe.
    always_comb begin
        bus_sel_nxt = (state_nxt == WRITE);
        busy_nxt    = (state_nxt == COLLECT) || (state_nxt == WRITE);
`ifdef IMEM_LOADER_READBACK_VERIFY_EN
        bus_sel_nxt = bus_sel_nxt || (state_nxt == VRD);
        busy_nxt    = busy_nxt || (state_nxt == VRD) || (state_nxt == VCHK);
`endif
    end

    // Byte lane insertion: byte k of a word lands in bits [8k+7:8k].
    always_comb begin
        word_nxt = word_q;
        if (accept) begin
            case (byte_idx)
                2'd0:    word_nxt[7:0]   = in_data;
                2'd1:    word_nxt[15:8]  = in_data;
                2'd2:    word_nxt[23:16] = in_data;
                default: word_nxt[31:24] = in_data;
            endcase
        end
    end

    // Assembly register. It has no reset because every lane is overwritten
    // before the word is used, and byte_idx restarts at lane 0.
    always_ff @(posedge clk) begin
        word_q <= word_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr           <= '0;
            byte_idx       <= 2'd0;
            word_count     <= '0;
            avm_address    <= '0;
            avm_byteenable <= 4'h0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            core_reset_n   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (restart) begin
                addr       <= '0;
                byte_idx   <= 2'd0;
                word_count <= '0;
            end else begin
                if (accept) begin
                    byte_idx <= byte_idx + 2'd1;
                end
                if (state == WRITE) begin
                    word_count <= word_count + 1'b1;
                end
                if (step) begin
                    addr <= addr + 1'b1;
                end
            end

            avm_write      <= (state_nxt == WRITE);
            avm_chipselect <= bus_sel_nxt;
            avm_byteenable <= bus_sel_nxt ? 4'hF : 4'h0;
            if (bus_sel_nxt) begin
                avm_address <= addr;
            end
            if (state_nxt == WRITE) begin
                avm_writedata <= word_nxt;
            end

            busy         <= busy_nxt;
            done         <= (state_nxt == DONE);
            core_reset_n <= (state_nxt == DONE);
        end
    end

`ifdef IMEM_LOADER_READBACK_VERIFY_EN
    logic error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= (state_nxt == ERROR);
        end
    end

    assign error = error_q;
`else
    logic unused_readdata;

    assign unused_readdata = ^avm_readdata;
    assign error           = 1'b0;
`endif

endmodule
